// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, presents it to instruction memory and registers
// {pc, instruction, valid} into IF/ID. Define IF_PERF_CNT_EN to add the perf_* counters.
module if_fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter logic [63:0] IMEM_BYTES = 64'd88,
    parameter logic [31:0] NOP_INSN   = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic [63:0] inst_address,
    input  logic [31:0] instruction_in,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid,
    output logic        fetch_halted
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    logic [63:0] pc;
    logic        fetch_ok;
    logic        unused_target_bits;

    // 65-bit sum so a pc near 2^64 cannot wrap into the legal window.
    assign fetch_ok           = ({1'b0, pc} + 65'd3) < {1'b0, IMEM_BYTES};
    assign inst_address       = pc;
    assign unused_target_bits = ^branch_target[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            pc                <= RESET_PC;
            if_id_pc          <= 64'h0;
            if_id_instruction <= NOP_INSN;
            if_id_valid       <= 1'b0;
            fetch_halted      <= 1'b0;
        end else if (branch_taken) begin
            pc                <= {branch_target[63:2], 2'b00};
            if_id_pc          <= 64'h0;
            if_id_instruction <= NOP_INSN;
            if_id_valid       <= 1'b0;
            fetch_halted      <= 1'b0;
        end else if (stall) begin
            pc                <= pc;
        end else if (fetch_halted || !fetch_ok) begin
            if_id_pc          <= 64'h0;
            if_id_instruction <= NOP_INSN;
            if_id_valid       <= 1'b0;
            fetch_halted      <= 1'b1;
        end else begin
            if_id_pc          <= pc;
            if_id_instruction <= instruction_in;
            if_id_valid       <= 1'b1;
            pc                <= pc + 64'd4;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic fetch_fire;
    logic stall_fire;

    assign fetch_fire = !branch_taken && !stall && !fetch_halted && fetch_ok;
    assign stall_fire = !branch_taken && stall;

    // All three counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt <= 32'h0;
            perf_stall_cnt <= 32'h0;
            perf_flush_cnt <= 32'h0;
        end else begin
            if (fetch_fire && perf_fetch_cnt != 32'hFFFFFFFF)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall_fire && perf_stall_cnt != 32'hFFFFFFFF)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (branch_taken && perf_flush_cnt != 32'hFFFFFFFF)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus randomized traffic
// compared against a behavioural model. Perf-counter checks only with IF_PERF_CNT_EN.
module tb_if_fetch_stage;

    localparam logic [63:0] IMEM_BYTES = 64'd88;
    localparam logic [31:0] NOP        = 32'h00000013;
    localparam logic [31:0] OOR_WORD   = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = 64'h0;
    logic [63:0] inst_address;
    logic [31:0] instruction_in;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
    logic        fetch_halted;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] imem [22];

    // Behavioural model state
    logic [63:0] m_pc;
    logic [63:0] m_ipc;
    logic [31:0] m_iinst;
    logic        m_ivalid;
    logic        m_halt;
    logic [31:0] m_cf, m_cs, m_cl;

    if_fetch_stage dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .inst_address      (inst_address),
        .instruction_in    (instruction_in),
        .if_id_pc          (if_id_pc),
        .if_id_instruction (if_id_instruction),
        .if_id_valid       (if_id_valid),
        .fetch_halted      (fetch_halted)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_flush_cnt    (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [63:0] a);
        if (a < IMEM_BYTES) return imem[int'(a / 64'd4)];
        return OOR_WORD;
    endfunction

    assign instruction_in = mem_rd(inst_address);

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFFFFFF) ? c : c + 32'd1;
    endfunction

    logic [161:0] obs;
    assign obs = {inst_address, if_id_pc, if_id_instruction, if_id_valid, fetch_halted};

    function automatic logic [161:0] exp_vec();
        return {m_pc, m_ipc, m_iinst, m_ivalid, m_halt};
    endfunction

    // Apply one cycle of inputs to DUT and model; returns #1 after the edge.
    task automatic tick(input logic r, input logic s, input logic b, input logic [63:0] t);
        reset = r; stall = s; branch_taken = b; branch_target = t;
        if (r) begin
            m_pc = 64'h0; m_ipc = 64'h0; m_iinst = NOP; m_ivalid = 1'b0; m_halt = 1'b0;
            m_cf = 0; m_cs = 0; m_cl = 0;
        end else if (b) begin
            m_pc = t & ~64'd3;
            m_ipc = 64'h0; m_iinst = NOP; m_ivalid = 1'b0; m_halt = 1'b0;
            m_cl = sat_inc(m_cl);
        end else if (s) begin
            m_cs = sat_inc(m_cs);
        end else if (m_halt) begin
            m_ipc = 64'h0; m_iinst = NOP; m_ivalid = 1'b0;
        end else if (m_pc <= IMEM_BYTES - 64'd4) begin
            m_ipc = m_pc; m_iinst = mem_rd(m_pc); m_ivalid = 1'b1;
            m_pc = m_pc + 64'd4;
            m_cf = sat_inc(m_cf);
        end else begin
            m_ipc = 64'h0; m_iinst = NOP; m_ivalid = 1'b0; m_halt = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        n_tests++;
        if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", obs, exp_vec());
        end
        n_tests++;
        if ({inst_address, if_id_instruction, if_id_valid} !== {64'h0, NOP, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_const: got pc=%h insn=%h v=%b want pc=0 insn=%h v=0",
                     inst_address, if_id_instruction, if_id_valid, NOP);
        end
    endtask

    task automatic test_fetch();
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0);
            n_tests++;
            if ({if_id_pc, if_id_instruction, if_id_valid, inst_address} !==
                {64'(4 * i), imem[i], 1'b1, 64'(4 * i + 4)}) begin
                n_fail++;
                $display("FAIL fetch_seq%0d: got ipc=%h insn=%h v=%b pc=%h want ipc=%h insn=%h v=1 pc=%h",
                         i, if_id_pc, if_id_instruction, if_id_valid, inst_address,
                         64'(4 * i), imem[i], 64'(4 * i + 4));
            end
        end
    endtask

    task automatic test_stall();
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 0, 0);
            n_tests++;
            if ({inst_address, if_id_pc, if_id_instruction, if_id_valid} !==
                {64'd8, 64'd4, imem[1], 1'b1}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got pc=%h ipc=%h insn=%h v=%b want pc=8 ipc=4 insn=%h v=1",
                         i, inst_address, if_id_pc, if_id_instruction, if_id_valid, imem[1]);
            end
        end
        tick(0, 0, 0, 0);
        n_tests++;
        if ({inst_address, if_id_pc, if_id_instruction} !== {64'd12, 64'd8, imem[2]}) begin
            n_fail++;
            $display("FAIL stall_resume: got pc=%h ipc=%h insn=%h want pc=c ipc=8 insn=%h",
                     inst_address, if_id_pc, if_id_instruction, imem[2]);
        end
    endtask

    task automatic test_branch_stall();
        tick(0, 1, 1, 64'h13);
        n_tests++;
        if ({inst_address, if_id_pc, if_id_instruction, if_id_valid} !==
            {64'h10, 64'h0, NOP, 1'b0}) begin
            n_fail++;
            $display("FAIL branch_over_stall: got pc=%h ipc=%h insn=%h v=%b want pc=10 ipc=0 insn=%h v=0",
                     inst_address, if_id_pc, if_id_instruction, if_id_valid, NOP);
        end
    endtask

    task automatic test_halt();
        int budget = 40;
        while (!m_halt && budget > 0) begin
            tick(0, 0, 0, 0);
            budget--;
        end
        n_tests++;
        if (budget == 0 || {fetch_halted, inst_address, if_id_valid} !== {1'b1, 64'd88, 1'b0}) begin
            n_fail++;
            $display("FAIL halt_entry: got halted=%b pc=%h v=%b want halted=1 pc=58 v=0",
                     fetch_halted, inst_address, if_id_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0);
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL halt_hold%0d: got %h want %h", i, obs, exp_vec());
            end
        end
        tick(0, 0, 1, 64'd4);
        n_tests++;
        if ({fetch_halted, inst_address} !== {1'b0, 64'd4}) begin
            n_fail++;
            $display("FAIL halt_clear: got halted=%b pc=%h want halted=0 pc=4",
                     fetch_halted, inst_address);
        end
    endtask

    task automatic test_mid_reset();
        int budget = 10;
        while (m_pc != 64'd20 && budget > 0) begin
            tick(0, 0, 0, 0);
            budget--;
        end
        tick(1, 0, 0, 0);
        n_tests++;
        if ({inst_address, if_id_valid, fetch_halted} !== {64'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset: got pc=%h v=%b halted=%b want pc=0 v=0 halted=0",
                     inst_address, if_id_valid, fetch_halted);
        end
`ifdef IF_PERF_CNT_EN
        n_tests++;
        if ({perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt} !== 96'h0) begin
            n_fail++;
            $display("FAIL mid_reset_cnt: got %h/%h/%h want 0/0/0",
                     perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt);
        end
`endif
    endtask

    task automatic test_random();
        logic r, s, b;
        logic [63:0] t;
        tick(1, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 49) == 0);
            s = ($urandom_range(0, 4) == 0);
            b = ($urandom_range(0, 11) == 0);
            t = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom}
                                            : 64'($urandom_range(0, 100));
            tick(r, s, b, t);
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_%0d: got %h want %h", i, obs, exp_vec());
            end
`ifdef IF_PERF_CNT_EN
            n_tests++;
            if ({perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt} !== {m_cf, m_cs, m_cl}) begin
                n_fail++;
                $display("FAIL random_cnt_%0d: got %h/%h/%h want %h/%h/%h", i,
                         perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt, m_cf, m_cs, m_cl);
            end
`endif
        end
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_perf();
        tick(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 0, 1, 64'h0);
        n_tests++;
        if ({perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt} !== {32'd5, 32'd2, 32'd1}) begin
            n_fail++;
            $display("FAIL perf_counts: got %0d/%0d/%0d want 5/2/1",
                     perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt);
        end
        force dut.perf_fetch_cnt = 32'hFFFFFFFF;
        #1;
        release dut.perf_fetch_cnt;
        m_cf = 32'hFFFFFFFF;
        tick(0, 0, 0, 0);
        n_tests++;
        if (perf_fetch_cnt !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL perf_saturate: got %h want ffffffff", perf_fetch_cnt);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 22; i++) imem[i] = $urandom;
        m_pc = 0; m_ipc = 0; m_iinst = NOP; m_ivalid = 0; m_halt = 0;
        m_cf = 0; m_cs = 0; m_cl = 0;
        test_reset();
        test_fetch();
        test_stall();
        test_branch_stall();
        test_halt();
        test_mid_reset();
`ifdef IF_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
